// File: rtl/climate_classifier_mc.sv
`default_nettype none
// climate_classifier_mc: multi-channel sample classifier with per-channel trend,
// pressure-drop alert and debounced stable condition.  Rev 1.0
module climate_classifier_mc #(
  parameter int NUM_CH      = 4,
  parameter int TEMP_W      = 32,
  parameter int PRES_W      = 32,
  parameter int SNOW_T_MIN  = -10,
  parameter int SNOW_T_MAX  = 10,
  parameter int SNOW_P_MIN  = 950,
  parameter int SNOW_P_MAX  = 1000,
  parameter int SUNNY_T_MIN = 11,
  parameter int SUNNY_T_MAX = 25,
  parameter int SUNNY_P_MIN = 1000,
  parameter int SUNNY_P_MAX = 1020,
  parameter int STORM_T_MIN = 26,
  parameter int STORM_P_MAX = 949,
  parameter int PDROP_ALERT = 20,
  parameter int DEBOUNCE    = 3,
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_ch,
  input  logic signed [TEMP_W-1:0] temperature,
  input  logic [PRES_W-1:0]        pressure,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_ch,
  output logic [2:0]               climate_condition,
  output logic [2:0]               stable_condition,
  output logic [1:0]               temp_trend,
  output logic                     pres_drop_alert,
  output logic                     ch_err,
  output logic                     busy
);

  localparam int CNTW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_UPDATE   = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [2:0] c_UNDEF = 3'd0;
  localparam logic [2:0] c_SNOW  = 3'd1;
  localparam logic [2:0] c_SUNNY = 3'd2;
  localparam logic [2:0] c_STORM = 3'd3;
  localparam logic [2:0] c_ERROR = 3'd4;

  localparam logic signed [TEMP_W-1:0] c_SNOW_T_MIN  = TEMP_W'(SNOW_T_MIN);
  localparam logic signed [TEMP_W-1:0] c_SNOW_T_MAX  = TEMP_W'(SNOW_T_MAX);
  localparam logic signed [TEMP_W-1:0] c_SUNNY_T_MIN = TEMP_W'(SUNNY_T_MIN);
  localparam logic signed [TEMP_W-1:0] c_SUNNY_T_MAX = TEMP_W'(SUNNY_T_MAX);
  localparam logic signed [TEMP_W-1:0] c_STORM_T_MIN = TEMP_W'(STORM_T_MIN);
  localparam logic [PRES_W-1:0] c_SNOW_P_MIN  = PRES_W'(SNOW_P_MIN);
  localparam logic [PRES_W-1:0] c_SNOW_P_MAX  = PRES_W'(SNOW_P_MAX);
  localparam logic [PRES_W-1:0] c_SUNNY_P_MIN = PRES_W'(SUNNY_P_MIN);
  localparam logic [PRES_W-1:0] c_SUNNY_P_MAX = PRES_W'(SUNNY_P_MAX);
  localparam logic [PRES_W-1:0] c_STORM_P_MAX = PRES_W'(STORM_P_MAX);
  localparam logic [PRES_W-1:0] c_PDROP       = PRES_W'(PDROP_ALERT);
  localparam logic [CW:0]       c_NUM_CH      = (CW + 1)'(NUM_CH);
  localparam logic [CNTW-1:0]   c_DEB         = CNTW'(DEBOUNCE);

  logic [1:0]               r_state;
  logic                     r_in_ready;
  logic [CW-1:0]            r_ch;
  logic signed [TEMP_W-1:0] r_temp;
  logic [PRES_W-1:0]        r_pres;
  logic [2:0]               r_raw;
  logic                     r_ch_err;

  logic                     r_out_valid;
  logic [CW-1:0]            r_out_ch;
  logic [2:0]               r_out_cond;
  logic [2:0]               r_out_stable;
  logic [1:0]               r_out_trend;
  logic                     r_out_alert;
  logic                     r_out_ch_err;

  logic                     r_prev_valid [NUM_CH];
  logic signed [TEMP_W-1:0] r_prev_temp  [NUM_CH];
  logic [PRES_W-1:0]        r_prev_pres  [NUM_CH];
  logic [2:0]               r_stable     [NUM_CH];
  logic [2:0]               r_last_raw   [NUM_CH];
  logic [CNTW-1:0]          r_cnt        [NUM_CH];

  logic        w_ch_err, w_snow, w_sunny, w_storm;
  logic [2:0]  w_class;
  logic [CW-1:0] w_idx;
  logic [1:0]  w_trend;
  logic        w_alert;
  logic [2:0]  w_new_last, w_new_stable;
  logic [CNTW-1:0] w_new_cnt;

  assign w_ch_err = ({1'b0, r_ch} >= c_NUM_CH);
  assign w_snow   = (r_temp >= c_SNOW_T_MIN) && (r_temp <= c_SNOW_T_MAX) &&
                    (r_pres >= c_SNOW_P_MIN) && (r_pres <= c_SNOW_P_MAX);
  assign w_sunny  = (r_temp >= c_SUNNY_T_MIN) && (r_temp <= c_SUNNY_T_MAX) &&
                    (r_pres >= c_SUNNY_P_MIN) && (r_pres <= c_SUNNY_P_MAX);
  assign w_storm  = (r_temp >= c_STORM_T_MIN) && (r_pres <= c_STORM_P_MAX);

  always_comb begin
    w_class = c_ERROR;
    if (w_ch_err)     w_class = c_ERROR;
    else if (w_snow)  w_class = c_SNOW;
    else if (w_sunny) w_class = c_SUNNY;
    else if (w_storm) w_class = c_STORM;
  end

  // An out-of-range channel never touches the history, so any in-range index is safe here
  assign w_idx = r_ch_err ? '0 : r_ch;

  always_comb begin
    w_trend = 2'b00;
    w_alert = 1'b0;
    if (r_prev_valid[w_idx]) begin
      if (r_temp > r_prev_temp[w_idx])      w_trend = 2'b01;
      else if (r_temp < r_prev_temp[w_idx]) w_trend = 2'b10;
      else                                  w_trend = 2'b11;
      w_alert = (r_prev_pres[w_idx] > r_pres) &&
                ((r_prev_pres[w_idx] - r_pres) >= c_PDROP);
    end
  end

  always_comb begin
    w_new_last = r_last_raw[w_idx];
    w_new_cnt  = r_cnt[w_idx];
    if (r_raw == r_last_raw[w_idx]) begin
      w_new_cnt = (r_cnt[w_idx] >= c_DEB) ? c_DEB : r_cnt[w_idx] + 1'b1;
    end else begin
      w_new_last = r_raw;
      w_new_cnt  = CNTW'(1);
    end
    w_new_stable = (w_new_cnt == c_DEB) ? r_raw : r_stable[w_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_ch         <= '0;
      r_temp       <= '0;
      r_pres       <= '0;
      r_raw        <= c_UNDEF;
      r_ch_err     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_cond   <= c_UNDEF;
      r_out_stable <= c_UNDEF;
      r_out_trend  <= 2'b00;
      r_out_alert  <= 1'b0;
      r_out_ch_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_ch       <= in_ch;
            r_temp     <= temperature;
            r_pres     <= pressure;
            r_in_ready <= 1'b0;
            r_state    <= S_CLASSIFY;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_CLASSIFY: begin
          r_raw    <= w_class;
          r_ch_err <= w_ch_err;
          r_state  <= S_UPDATE;
        end
        S_UPDATE: begin
          r_out_ch     <= r_ch;
          r_out_cond   <= r_raw;
          r_out_stable <= r_ch_err ? c_UNDEF : w_new_stable;
          r_out_trend  <= r_ch_err ? 2'b00 : w_trend;
          r_out_alert  <= r_ch_err ? 1'b0 : w_alert;
          r_out_ch_err <= r_ch_err;
          r_out_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_prev_valid[i] <= 1'b0;
        r_prev_temp[i]  <= '0;
        r_prev_pres[i]  <= '0;
        r_stable[i]     <= c_UNDEF;
        r_last_raw[i]   <= c_UNDEF;
        r_cnt[i]        <= '0;
      end
    end else if (r_state == S_UPDATE && !r_ch_err) begin
      r_prev_valid[w_idx] <= 1'b1;
      r_prev_temp[w_idx]  <= r_temp;
      r_prev_pres[w_idx]  <= r_pres;
      r_stable[w_idx]     <= w_new_stable;
      r_last_raw[w_idx]   <= w_new_last;
      r_cnt[w_idx]        <= w_new_cnt;
    end
  end

  assign in_ready          = r_in_ready;
  assign out_valid         = r_out_valid;
  assign out_ch            = r_out_ch;
  assign climate_condition = r_out_cond;
  assign stable_condition  = r_out_stable;
  assign temp_trend        = r_out_trend;
  assign pres_drop_alert   = r_out_alert;
  assign ch_err            = r_out_ch_err;
  assign busy              = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_climate_classifier_mc.sv
`default_nettype none
// tb_climate_classifier_mc: directed table, corner sequences and random samples
// checked against a behavioural model of the classifier.  Rev 1.0
module tb_climate_classifier_mc;

  localparam int NCH   = 3;
  localparam int DEB   = 3;
  localparam int PDROP = 20;

  logic               clk, rst;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [1:0]         in_ch, out_ch;
  logic signed [31:0] temperature;
  logic [31:0]        pressure;
  logic [2:0]         climate_condition, stable_condition;
  logic [1:0]         temp_trend;
  logic               pres_drop_alert, ch_err, busy;

  climate_classifier_mc #(.NUM_CH(NCH), .DEBOUNCE(DEB), .PDROP_ALERT(PDROP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .temperature(temperature), .pressure(pressure),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .climate_condition(climate_condition), .stable_condition(stable_condition),
    .temp_trend(temp_trend), .pres_drop_alert(pres_drop_alert),
    .ch_err(ch_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cond; int stable; int trend; int alert; int cherr; int och; } exp_t;
  typedef struct { int ch; int t; int p; int cond; int stable; int trend; int alert; } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state: per-channel history and current run length of identical classes
  int     m_pv   [NCH];
  int     m_pt   [NCH];
  longint m_pp   [NCH];
  int     m_last [NCH];
  int     m_run  [NCH];
  int     m_st   [NCH];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cls(input int t, input longint p);
    if (t >= -10 && t <= 10 && p >= 950 && p <= 1000) return 1;
    if (t >= 11 && t <= 25 && p >= 1000 && p <= 1020) return 2;
    if (t >= 26 && p <= 949) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pv[i] = 0; m_pt[i] = 0; m_pp[i] = 0; m_last[i] = 0; m_run[i] = 0; m_st[i] = 0;
    end
  endtask

  task automatic model(input int ch, input int t, input longint p, output exp_t e);
    int raw;
    e.och = ch;
    if (ch >= NCH) begin
      e.cond = 4; e.stable = 0; e.trend = 0; e.alert = 0; e.cherr = 1;
      return;
    end
    raw = cls(t, p);
    e.cond = raw; e.cherr = 0;
    if (m_pv[ch] == 0) begin
      e.trend = 0; e.alert = 0;
    end else begin
      e.trend = (t > m_pt[ch]) ? 1 : (t < m_pt[ch]) ? 2 : 3;
      e.alert = ((m_pp[ch] - p) >= PDROP) ? 1 : 0;
    end
    if (raw == m_last[ch]) m_run[ch]++;
    else begin m_last[ch] = raw; m_run[ch] = 1; end
    if (m_run[ch] >= DEB) m_st[ch] = raw;
    e.stable = m_st[ch];
    m_pv[ch] = 1; m_pt[ch] = t; m_pp[ch] = p;
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, "_cond"},   int'(climate_condition), e.cond);
    chk({tag, "_stable"}, int'(stable_condition),  e.stable);
    chk({tag, "_trend"},  int'(temp_trend),        e.trend);
    chk({tag, "_alert"},  int'(pres_drop_alert),   e.alert);
    chk({tag, "_ch_err"}, int'(ch_err),            e.cherr);
    chk({tag, "_out_ch"}, int'(out_ch),            e.och);
  endtask

  // One transaction; out_ready is held low for 'hold' cycles once the result is up
  task automatic txn(input string tag, input int ch, input int t, input int p,
                     input int hold, input bit poke, input exp_t e);
    int n;
    int lat;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin chk({tag, "_in_ready_timeout"}, 0, 1); return; end
    in_valid = 1'b1; in_ch = 2'(ch); temperature = t; pressure = 32'(p);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, lat, 3);
    if (!out_valid) return;
    chk_fields(tag, e);
    for (int k = 0; k < hold; k++) begin
      if (poke) begin in_valid = 1'b1; in_ch = 2'd0; temperature = 100; pressure = 500; end
      @(posedge clk); #1;
      chk({tag, "_hold_out_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_in_ready"},  int'(in_ready),  0);
      chk_fields({tag, "_hold"}, e);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_release_out_valid"}, int'(out_valid), 0);
    chk({tag, "_release_in_ready"},  int'(in_ready),  1);
  endtask

  vec_t tbl[16];
  exp_t e, m;
  int   seen;
  int   lt[NCH], lp[NCH];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_ch = '0; temperature = '0; pressure = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy",      int'(busy), 0);
    chk("reset_cond",      int'(climate_condition), 0);
    chk("reset_stable",    int'(stable_condition), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", int'(in_ready), 1);

    tbl[0]  = '{0,   5,  975, 1, 0, 0, 0};
    tbl[1]  = '{1,  20, 1010, 2, 0, 0, 0};
    tbl[2]  = '{1,  20, 1010, 2, 0, 3, 0};
    tbl[3]  = '{1,  20, 1010, 2, 2, 3, 0};
    tbl[4]  = '{1,  30,  900, 3, 2, 1, 1};
    tbl[5]  = '{2,  30, 1000, 4, 0, 0, 0};
    tbl[6]  = '{2,  28,  975, 4, 0, 2, 1};
    tbl[7]  = '{2,  28,  990, 4, 4, 3, 0};
    tbl[8]  = '{0, -10,  950, 1, 0, 2, 1};
    tbl[9]  = '{0,  10, 1000, 1, 1, 1, 0};
    tbl[10] = '{0,  25, 1020, 2, 1, 1, 0};
    tbl[11] = '{0,  26,  949, 3, 1, 1, 1};
    tbl[12] = '{0,  25,  949, 4, 1, 2, 0};
    tbl[13] = '{0, -11,  975, 4, 1, 2, 0};
    tbl[14] = '{0, -11,  955, 4, 4, 3, 1};
    tbl[15] = '{0, -11,  936, 4, 4, 3, 0};
    for (int i = 0; i < 16; i++) begin
      model(tbl[i].ch, tbl[i].t, tbl[i].p, m);
      e = '{tbl[i].cond, tbl[i].stable, tbl[i].trend, tbl[i].alert, 0, tbl[i].ch};
      txn($sformatf("vec%0d", i), tbl[i].ch, tbl[i].t, tbl[i].p, 0, 1'b0, e);
    end

    // Backpressure: result frozen for 10 cycles while a competing sample is offered
    model(0, 15, 1005, e);
    txn("hold", 0, 15, 1005, 10, 1'b1, e);
    model(0, 15, 1005, e);
    txn("after_hold", 0, 15, 1005, 0, 1'b0, e);

    // Out-of-range channel must leave every history untouched
    model(3, 50, 800, e);
    txn("ch_err", 3, 50, 800, 0, 1'b0, e);
    model(2, 28, 990, e);
    txn("after_ch_err", 2, 28, 990, 0, 1'b0, e);

    // Reset while the sample sits in CLASSIFY
    in_valid = 1'b1; in_ch = 2'd1; temperature = 20; pressure = 1010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy", int'(busy), 1);
    rst = 1'b1;
    #2;
    chk("abort_rst_out_valid", int'(out_valid), 0);
    chk("abort_rst_in_ready",  int'(in_ready), 0);
    chk("abort_rst_busy",      int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_out_valid", seen, 0);
    model(1, 20, 1010, e);
    txn("post_abort_ch1", 1, 20, 1010, 0, 1'b0, e);
    model(0, 12, 1001, e);
    txn("post_abort_ch0", 0, 12, 1001, 0, 1'b0, e);

    for (int i = 0; i < NCH; i++) begin lt[i] = 0; lp[i] = 975; end
    for (int i = 0; i < 80; i++) begin
      int ch, t, p, hold;
      ch = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, NCH - 1));
      if (ch < NCH && $urandom_range(0, 2) == 0) begin
        t = lt[ch]; p = lp[ch];
      end else begin
        t = int'($urandom_range(0, 60)) - 20;
        p = int'($urandom_range(930, 1030));
      end
      if (ch < NCH) begin lt[ch] = t; lp[ch] = p; end
      hold = int'($urandom_range(0, 2));
      model(ch, t, p, e);
      txn($sformatf("rand%0d", i), ch, t, p, hold, hold > 0, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
